spi_master: RTL and testbench

Single-transaction SPI master that generates `sclk`, `ss`, `mosi` and a `tx_end` strobe for the SPI slave on the same system clock. It shifts out a `bits_num`-bit word and captures `miso` in the SPI mode set by parameter, then presents the received word with a one-cycle `done` pulse. It sits directly upstream of the SPI slave and drives all of that slave's bus inputs.

---
 rtl/spi_master.sv | 131 +++++++++++++
 tb/tb_spi_master.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Single-transaction SPI master: shifts a bits_num-bit word out on mosi while
// capturing miso in the mode given by {CPOL, CPHA}, then pulses done/tx_end.
module spi_master #(
    parameter logic [1:0] mode     = 2'b00,
    parameter int         bits_num = 8,
    parameter int         clk_div  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [bits_num-1:0] data_in,
    input  logic                miso,
    output logic                sclk,
    output logic                ss,
    output logic                mosi,
    output logic                tx_end,
    output logic                busy,
    output logic                done,
    output logic [bits_num-1:0] data_out,
    output logic [2:0]          state_dbg
);

    localparam logic cpol   = mode[1];
    localparam logic cpha   = mode[0];
    localparam int   DIV_W  = $clog2(clk_div);
    localparam int   EDGE_W = $clog2(2 * bits_num + 1);

    // Handshake: start is a level request, honoured only while busy is low;
    // the cycle that sees start high in IDLE is the acceptance cycle.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        TRANSFER = 3'd2,
        TRAIL    = 3'd3,
        ST_END   = 3'd4
    } state_t;

    state_t              state, state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [EDGE_W-1:0]   edge_k;
    logic [bits_num-1:0] tx_shift;
    logic [bits_num-1:0] rx_shift;
    logic                half_wrap;
    logic                last_edge;
    logic                edge_now;
    logic                sample_now;
    logic                drive_now;

    assign half_wrap = (div_cnt == DIV_W'(clk_div - 1));
    assign edge_k    = edge_cnt + EDGE_W'(1);
    assign last_edge = (edge_k == EDGE_W'(2 * bits_num));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Edge 1 is launched from the last SETUP cycle, so edge k lands on sclk
    // exactly k half-periods after ss falls.
    always_comb begin
        state_next = state;
        edge_now   = 1'b0;
        sample_now = 1'b0;
        drive_now  = 1'b0;
        case (state)
            IDLE:     if (start) state_next = SETUP;
            SETUP:    if (half_wrap) state_next = TRANSFER;
            TRANSFER: if (half_wrap && last_edge) state_next = TRAIL;
            TRAIL:    if (half_wrap) state_next = ST_END;
            ST_END:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (state == SETUP || state == TRANSFER) edge_now = half_wrap;
        sample_now = edge_now && (cpha ? !edge_k[0] : edge_k[0]);
        drive_now  = edge_now && (cpha ? edge_k[0] : (!edge_k[0] && !last_edge));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            if (state == SETUP || state == TRANSFER || state == TRAIL)
                div_cnt <= half_wrap ? '0 : div_cnt + 1'b1;
            else
                div_cnt <= '0;
            if (state == IDLE)  edge_cnt <= '0;
            else if (edge_now)  edge_cnt <= edge_k;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shift <= '0;
            rx_shift <= '0;
            sclk     <= cpol;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            tx_end   <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            tx_end <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE && start) begin
                // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for it.
                tx_shift <= cpha ? data_in : (data_in << 1);
                rx_shift <= '0;
                ss       <= 1'b0;
                if (!cpha) mosi <= data_in[bits_num-1];
            end
            if (edge_now)   sclk <= ~sclk;
            if (sample_now) rx_shift <= {rx_shift[bits_num-2:0], miso};
            if (drive_now) begin
                mosi     <= tx_shift[bits_num-1];
                tx_shift <= tx_shift << 1;
            end
            if (state == TRAIL && state_next == ST_END) begin
                ss       <= 1'b1;
                mosi     <= 1'b0;
                tx_end   <= 1'b1;
                done     <= 1'b1;
                data_out <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: five instances (all four modes plus a clk_div=2, 16-bit
// build) driven from a vector table, hand-written corner sequences and random transfers.
module tb_spi_master;

    localparam int         NI        = 5;
    localparam int         N_OF [NI] = '{8, 8, 8, 8, 16};
    localparam int         CD_OF[NI] = '{4, 4, 4, 4, 2};
    localparam logic [1:0] MD_OF[NI] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    logic        clk;
    logic        reset;
    logic        start_a[NI];
    logic [15:0] din_a  [NI];
    logic        miso_a [NI];
    logic        sclk_a [NI];
    logic        ss_a   [NI];
    logic        mosi_a [NI];
    logic        txe_a  [NI];
    logic        busy_a [NI];
    logic        done_a [NI];
    logic [7:0]  dout0, dout1, dout2, dout3;
    logic [15:0] dout4;
    logic [2:0]  st_a   [NI];

    // Slave / observer model state, one slot per instance
    bit          loop_a    [NI] = '{default: 1'b0};
    logic [15:0] slv_word  [NI] = '{default: 16'h0};
    logic        slv_bit   [NI] = '{default: 1'b0};
    logic [15:0] mosi_cap  [NI] = '{default: 16'h0};
    int          edges     [NI] = '{default: 0};
    int          edge_err  [NI] = '{default: 0};
    int          ss_fall_cyc[NI] = '{default: 0};
    int          hi_len    [NI] = '{default: 0};
    int          last_gap  [NI] = '{default: 0};
    int          done_cnt  [NI] = '{default: 0};
    logic        prev_ss   [NI] = '{default: 1'b1};
    logic        prev_sclk [NI] = '{default: 1'b0};

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          inst;
        logic [15:0] din;
        logic [15:0] sw;
        bit          lp;
        int          poke;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[7];

    spi_master #(.mode(2'b00), .bits_num(8), .clk_div(4)) u_m00 (
        .clk(clk), .reset(reset), .start(start_a[0]), .data_in(din_a[0][7:0]), .miso(miso_a[0]),
        .sclk(sclk_a[0]), .ss(ss_a[0]), .mosi(mosi_a[0]), .tx_end(txe_a[0]), .busy(busy_a[0]),
        .done(done_a[0]), .data_out(dout0), .state_dbg(st_a[0]));
    spi_master #(.mode(2'b01), .bits_num(8), .clk_div(4)) u_m01 (
        .clk(clk), .reset(reset), .start(start_a[1]), .data_in(din_a[1][7:0]), .miso(miso_a[1]),
        .sclk(sclk_a[1]), .ss(ss_a[1]), .mosi(mosi_a[1]), .tx_end(txe_a[1]), .busy(busy_a[1]),
        .done(done_a[1]), .data_out(dout1), .state_dbg(st_a[1]));
    spi_master #(.mode(2'b10), .bits_num(8), .clk_div(4)) u_m10 (
        .clk(clk), .reset(reset), .start(start_a[2]), .data_in(din_a[2][7:0]), .miso(miso_a[2]),
        .sclk(sclk_a[2]), .ss(ss_a[2]), .mosi(mosi_a[2]), .tx_end(txe_a[2]), .busy(busy_a[2]),
        .done(done_a[2]), .data_out(dout2), .state_dbg(st_a[2]));
    spi_master #(.mode(2'b11), .bits_num(8), .clk_div(4)) u_m11 (
        .clk(clk), .reset(reset), .start(start_a[3]), .data_in(din_a[3][7:0]), .miso(miso_a[3]),
        .sclk(sclk_a[3]), .ss(ss_a[3]), .mosi(mosi_a[3]), .tx_end(txe_a[3]), .busy(busy_a[3]),
        .done(done_a[3]), .data_out(dout3), .state_dbg(st_a[3]));
    spi_master #(.mode(2'b00), .bits_num(16), .clk_div(2)) u_w16 (
        .clk(clk), .reset(reset), .start(start_a[4]), .data_in(din_a[4]), .miso(miso_a[4]),
        .sclk(sclk_a[4]), .ss(ss_a[4]), .mosi(mosi_a[4]), .tx_end(txe_a[4]), .busy(busy_a[4]),
        .done(done_a[4]), .data_out(dout4), .state_dbg(st_a[4]));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    always_comb begin
        for (int i = 0; i < NI; i++) miso_a[i] = loop_a[i] ? mosi_a[i] : slv_bit[i];
    end

    // ---------------- slave model / bus observer ----------------
    for (genvar g = 0; g < NI; g++) begin : g_mon
        always @(negedge clk) begin
            int k;
            if (!reset) begin
                if (prev_ss[g] && !ss_a[g]) begin
                    ss_fall_cyc[g] = cyc;
                    last_gap[g]    = hi_len[g];
                    hi_len[g]      = 0;
                    edges[g]       = 0;
                    mosi_cap[g]    = 16'h0;
                    if (MD_OF[g][0] == 1'b0) slv_bit[g] = slv_word[g][N_OF[g]-1];
                end else if (!prev_ss[g] && !ss_a[g] && sclk_a[g] != prev_sclk[g]) begin
                    edges[g] = edges[g] + 1;
                    k = edges[g];
                    if (cyc != ss_fall_cyc[g] + k * CD_OF[g]) edge_err[g] = edge_err[g] + 1;
                    if ((MD_OF[g][0] == 1'b1) == (k % 2 == 0))
                        mosi_cap[g] = {mosi_cap[g][14:0], mosi_a[g]};
                    if (MD_OF[g][0] == 1'b0 && k % 2 == 0 && k < 2 * N_OF[g])
                        slv_bit[g] = slv_word[g][N_OF[g]-1-k/2];
                    if (MD_OF[g][0] == 1'b1 && k % 2 == 1)
                        slv_bit[g] = slv_word[g][N_OF[g]-1-(k-1)/2];
                end
                if (ss_a[g])   hi_len[g]   = hi_len[g] + 1;
                if (done_a[g]) done_cnt[g] = done_cnt[g] + 1;
            end
            prev_ss[g]   = ss_a[g];
            prev_sclk[g] = sclk_a[g];
        end
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [15:0] get_dout(input int i);
        case (i)
            0:       return {8'h0, dout0};
            1:       return {8'h0, dout1};
            2:       return {8'h0, dout2};
            3:       return {8'h0, dout3};
            default: return dout4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_idle(input int i);
        int cnt = 0;
        while (busy_a[i] && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("idle_before_start", 32'(busy_a[i]), 32'd0);
    endtask

    // ---------------- driver ----------------
    task automatic do_xfer(input int i, input logic [15:0] din, input logic [15:0] sw,
                           input bit lp, input int poke, input logic [15:0] exp);
        int          n, cd, t0, d0, e0, cnt;
        bit          poke_on;
        logic [15:0] mask;
        n    = N_OF[i];
        cd   = CD_OF[i];
        mask = 16'((32'd1 << n) - 1);
        wait_idle(i);
        check("sclk_idle_before", 32'(sclk_a[i]), 32'(MD_OF[i][1]));
        loop_a[i]   = lp;
        slv_word[i] = sw;
        din_a[i]    = din;
        start_a[i]  = 1'b1;
        t0 = cyc;
        d0 = done_cnt[i];
        e0 = edge_err[i];
        @(negedge clk);
        start_a[i] = 1'b0;
        din_a[i]   = 16'($urandom);
        poke_on = 1'b0;
        cnt = 0;
        while (cnt < 400) begin
            if (done_a[i]) break;
            if (poke_on) begin
                start_a[i] = 1'b0;
                poke_on    = 1'b0;
            end
            if (poke >= 0 && cyc == t0 + poke) begin
                start_a[i] = 1'b1;
                din_a[i]   = ~din;
                poke_on    = 1'b1;
            end
            @(negedge clk);
            cnt++;
        end
        check("done_seen",      32'(done_a[i]), 32'd1);
        check("done_cycle",     32'(cyc - t0), 32'(1 + (2 * n + 1) * cd));
        check("tx_end_at_done", 32'(txe_a[i]), 32'd1);
        check("ss_at_done",     32'(ss_a[i]), 32'd1);
        check("mosi_at_done",   32'(mosi_a[i]), 32'd0);
        check("sclk_at_done",   32'(sclk_a[i]), 32'(MD_OF[i][1]));
        check("data_out",       32'(get_dout(i)), 32'(exp));
        check("mosi_bits",      32'(mosi_cap[i]), 32'(din & mask));
        check("edge_count",     32'(edges[i]), 32'(2 * n));
        check("edge_timing",    32'(edge_err[i] - e0), 32'd0);
        check("ss_fall_cycle",  32'(ss_fall_cyc[i] - t0), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy_a[i]), 32'd0);
        check("done_one_cycle",  32'(done_a[i]), 32'd0);
        check("tx_end_one_cycle", 32'(txe_a[i]), 32'd0);
        if (poke >= 0) begin
            repeat (100) @(negedge clk);
            check("single_done",  32'(done_cnt[i] - d0), 32'd1);
            check("data_out_hold", 32'(get_dout(i)), 32'(exp));
        end
    endtask

    task automatic held_start();
        logic [15:0] vals[3];
        int          t0, cnt, d0;
        vals[0] = 16'h01;
        vals[1] = 16'h80;
        vals[2] = 16'hFF;
        wait_idle(0);
        loop_a[0]  = 1'b1;
        din_a[0]   = vals[0];
        start_a[0] = 1'b1;
        t0 = cyc;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            cnt = 0;
            while (!done_a[0] && cnt < 400) begin
                @(negedge clk);
                cnt++;
            end
            check("held_done",       32'(done_a[0]), 32'd1);
            check("held_done_cycle", 32'(cyc - t0), 32'(1 + 17 * 4));
            check("held_tx_end",     32'(txe_a[0]), 32'd1);
            check("held_data_out",   32'(dout0), 32'(vals[j]));
            if (j > 0) check("held_ss_gap", 32'(last_gap[0]), 32'd2);
            if (j < 2) din_a[0] = vals[j+1];
            else       start_a[0] = 1'b0;
            @(negedge clk);
            check("held_tx_end_width", 32'(txe_a[0]), 32'd0);
            t0 = cyc;
        end
        d0 = done_cnt[0];
        repeat (80) @(negedge clk);
        check("held_no_fourth", 32'(done_cnt[0] - d0), 32'd0);
    endtask

    task automatic reset_mid();
        int t0, d0;
        wait_idle(0);
        loop_a[0]  = 1'b1;
        din_a[0]   = 16'h5B;
        start_a[0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_a[0] = 1'b0;
        while (cyc < t0 + 1 + 7 * 4) @(negedge clk);
        check("edge7_sclk", 32'(sclk_a[0]), 32'(!MD_OF[0][1]));
        d0 = done_cnt[0];
        reset = 1'b1;
        #1;
        check("rst_ss",       32'(ss_a[0]), 32'd1);
        check("rst_sclk",     32'(sclk_a[0]), 32'(MD_OF[0][1]));
        check("rst_busy",     32'(busy_a[0]), 32'd0);
        check("rst_data_out", 32'(dout0), 32'd0);
        check("rst_tx_end",   32'(txe_a[0]), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        check("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        do_xfer(0, 16'h69, 16'h00, 1'b1, -1, 16'h69);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0;
            din_a[i]   = 16'h0;
        end
        vt[0] = '{0, 16'h00A5, 16'h0000, 1'b1, -1, 16'h00A5};
        vt[1] = '{1, 16'h00C3, 16'h003C, 1'b0, -1, 16'h003C};
        vt[2] = '{2, 16'h00C3, 16'h003C, 1'b0, -1, 16'h003C};
        vt[3] = '{3, 16'h00C3, 16'h003C, 1'b0, -1, 16'h003C};
        vt[4] = '{4, 16'h8001, 16'h0000, 1'b1, -1, 16'h8001};
        vt[5] = '{0, 16'h005A, 16'h0096, 1'b0, -1, 16'h0096};
        vt[6] = '{0, 16'h003C, 16'h0077, 1'b0, 10, 16'h0077};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_ss",       32'(ss_a[i]), 32'd1);
            check("reset_sclk",     32'(sclk_a[i]), 32'(MD_OF[i][1]));
            check("reset_mosi",     32'(mosi_a[i]), 32'd0);
            check("reset_busy",     32'(busy_a[i]), 32'd0);
            check("reset_done",     32'(done_a[i]), 32'd0);
            check("reset_tx_end",   32'(txe_a[i]), 32'd0);
            check("reset_data_out", 32'(get_dout(i)), 32'd0);
            check("reset_state",    32'(st_a[i]), 32'd0);
        end

        for (int v = 0; v < 7; v++)
            do_xfer(vt[v].inst, vt[v].din, vt[v].sw, vt[v].lp, vt[v].poke, vt[v].exp);

        held_start();
        reset_mid();

        for (int r = 0; r < 24; r++) begin
            int          i;
            logic [15:0] din, sw, mask;
            bit          lp;
            i    = $urandom_range(0, NI - 1);
            din  = 16'($urandom);
            sw   = 16'($urandom);
            lp   = 1'($urandom_range(0, 1));
            mask = 16'((32'd1 << N_OF[i]) - 1);
            do_xfer(i, din, sw, lp, -1, lp ? (din & mask) : (sw & mask));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
